// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU op classes and the control bundle
// that travels from ID through EX/MEM/WB.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    logic    reg_dst;
    alu_op_t alu_op;
  } ctrl_t;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } sq_state_t;

  // Raw opcode decode; the reg_write-to-$0 suppression is applied by the caller,
  // which knows the destination field.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports with write-through bypass, one write port.
// $0 reads as zero; no backpressure, writes land on the rising edge.
module reg_file
  import mips_pkg::*;
#(
  parameter int RF_DEPTH = 32,
  parameter int DW       = 32,
  parameter int AW       = $clog2(RF_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] regs [RF_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Bypass lets ID see a value WB is writing in the same cycle.
  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (we && (wa == ra1)) rd1 = wd;
    if (we && (wa == ra2)) rd2 = wd;
    if (ra1 == '0) rd1 = '0;
    if (ra2 == '0) rd2 = '0;
  end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: decode, register read, load-use stall, jump/branch squash; ID/EX latency 1 cycle.
// Stall holds IF for one cycle per load-use pair (only with ID_HAZARD_DETECT_EN defined).
module id_stage
  import mips_pkg::*;
#(
  parameter int RF_DEPTH = 32,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instr_in,
  input  logic [31:0]   pc_in,
  input  logic          flush_in,
  input  logic          wb_we,
  input  logic [4:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          jump,
  output logic [25:0]   jump_add,
  output logic          stall,
  output logic [31:0]   ex_pc,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_to_reg,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_branch,
  output logic          ex_alu_src,
  output logic          ex_reg_dst,
  output logic [1:0]    ex_alu_op,
  output logic          illegal_op
);

  localparam int AW = $clog2(RF_DEPTH);

  logic [5:0]    opcode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    dest;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  ctrl_t         dec_ctrl;
  logic          dec_legal;
  logic          accept;
  ctrl_t         ex_ctrl;
  sq_state_t     state;

  assign opcode   = instr_in[31:26];
  assign rs       = instr_in[25:21];
  assign rt       = instr_in[20:16];
  assign rd       = instr_in[15:11];
  assign jump_add = instr_in[25:0];

  reg_file #(
    .RF_DEPTH (RF_DEPTH),
    .DW       (DW)
  ) u_reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (rs[AW-1:0]),
    .ra2 (rt[AW-1:0]),
    .rd1 (rs_data),
    .rd2 (rt_data),
    .we  (wb_we),
    .wa  (wb_addr[AW-1:0]),
    .wd  (wb_data)
  );

  always_comb begin
    dec_ctrl  = decode_ctrl(opcode);
    dec_legal = op_legal(opcode);
    dest      = dec_ctrl.reg_dst ? rd : rt;
    // Writes to $0 are dropped here so the all-zero word decodes as a NOP.
    if (dest == '0) dec_ctrl.reg_write = 1'b0;
  end

`ifdef ID_HAZARD_DETECT_EN
  logic uses_rt;
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  assign stall   = !rst && (state == RUN) && !flush_in && ex_ctrl.mem_read &&
                   (ex_rt != '0) && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
`else
  assign stall = 1'b0;
`endif

  // An instruction is only acted upon when nothing of higher priority kills it.
  assign accept = (state == RUN) && !flush_in && !stall;
  assign jump   = !rst && accept && (opcode == OP_J);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else if (flush_in) begin
      state <= SQUASH;
    end else if (state == SQUASH) begin
      state <= RUN;
    end else if (jump) begin
      state <= SQUASH;
    end else begin
      state <= RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl    <= '0;
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      illegal_op <= 1'b0;
    end else begin
      ex_ctrl    <= accept ? dec_ctrl : '0;
      ex_pc      <= pc_in;
      ex_rs_data <= rs_data;
      ex_rt_data <= rt_data;
      ex_imm     <= {{(DW-16){instr_in[15]}}, instr_in[15:0]};
      ex_rs      <= rs;
      ex_rt      <= rt;
      ex_rd      <= rd;
      if (accept && !dec_legal) illegal_op <= 1'b1;
    end
  end

  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_reg_dst    = ex_ctrl.reg_dst;
  assign ex_alu_op     = ex_ctrl.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Directed plus randomized stimulus for id_stage, checked against a per-instruction behavioural model.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        flush_in;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        jump;
  logic [25:0] jump_add;
  logic        stall;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_alu_src;
  logic        ex_reg_dst;
  logic [1:0]  ex_alu_op;
  logic        illegal_op;

  id_stage dut (
    .clk           (clk),
    .rst           (rst),
    .instr_in      (instr_in),
    .pc_in         (pc_in),
    .flush_in      (flush_in),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .jump          (jump),
    .jump_add      (jump_add),
    .stall         (stall),
    .ex_pc         (ex_pc),
    .ex_rs_data    (ex_rs_data),
    .ex_rt_data    (ex_rt_data),
    .ex_imm        (ex_imm),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_branch     (ex_branch),
    .ex_alu_src    (ex_alu_src),
    .ex_reg_dst    (ex_reg_dst),
    .ex_alu_op     (ex_alu_op),
    .illegal_op    (illegal_op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  // Model state: architectural registers, what sits in ID/EX that matters for
  // hazards, whether the next fetch is on the wrong path, and the sticky flag.
  logic [31:0] m_rf [32];
  bit          m_mem_read;
  logic [4:0]  m_rt;
  bit          m_kill;
  bit          m_illegal;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] read_val(input logic [4:0] a, input bit we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return m_rf[a];
  endfunction

  task automatic step(input bit r, input logic [31:0] ins, input logic [31:0] pc, input bit fl,
                      input bit we, input logic [4:0] wa, input logic [31:0] wd);
    logic [5:0]  op;
    logic [4:0]  f_rs, f_rt, f_rd;
    bit          legal, uses_rt, hz, acc, ej;
    logic [8:0]  ctl;
    logic [31:0] e_rs_d, e_rt_d, e_imm, e_pc;
    logic [14:0] e_fields;

    rst = r; instr_in = ins; pc_in = pc; flush_in = fl;
    wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    op    = ins[31:26];
    f_rs  = ins[25:21];
    f_rt  = ins[20:16];
    f_rd  = ins[15:11];
    legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h02);
    uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    hz = 1'b0;
`ifdef ID_HAZARD_DETECT_EN
    hz = !r && !m_kill && !fl && m_mem_read && (m_rt != 5'd0) &&
         ((m_rt == f_rs) || (uses_rt && (m_rt == f_rt)));
`endif
    acc = !r && !fl && !m_kill && !hz;
    ej  = acc && (op == 6'h02);
    chk("jump", {63'd0, jump}, {63'd0, ej});
    chk("jump_add", {38'd0, jump_add}, {38'd0, ins[25:0]});
    chk("stall", {63'd0, stall}, {63'd0, hz});

    // {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op}
    ctl = 9'd0;
    if (acc) begin
      case (op)
        6'h00:   ctl = {(f_rd != 5'd0), 6'b000001, 2'b10};
        6'h23:   ctl = {(f_rt != 5'd0), 6'b110010, 2'b00};
        6'h2B:   ctl = {1'b0, 6'b001010, 2'b00};
        6'h04:   ctl = {1'b0, 6'b000100, 2'b01};
        default: ctl = 9'd0;
      endcase
    end
    e_rs_d   = r ? 32'd0 : read_val(f_rs, we, wa, wd);
    e_rt_d   = r ? 32'd0 : read_val(f_rt, we, wa, wd);
    e_imm    = r ? 32'd0 : {{16{ins[15]}}, ins[15:0]};
    e_pc     = r ? 32'd0 : pc;
    e_fields = r ? 15'd0 : {f_rs, f_rt, f_rd};

    if (r) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_kill = 1'b0; m_illegal = 1'b0; m_mem_read = 1'b0; m_rt = 5'd0;
    end else begin
      if (we && wa != 5'd0) m_rf[wa] = wd;
      m_kill     = fl || ej;
      m_illegal  = m_illegal || (acc && !legal);
      m_mem_read = ctl[6];
      m_rt       = f_rt;
    end

    @(posedge clk);
    #1;
    chk("ex_ctrl", {55'd0, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                    ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op}, {55'd0, ctl});
    chk("ex_rs_data", {32'd0, ex_rs_data}, {32'd0, e_rs_d});
    chk("ex_rt_data", {32'd0, ex_rt_data}, {32'd0, e_rt_d});
    chk("ex_imm", {32'd0, ex_imm}, {32'd0, e_imm});
    chk("ex_pc", {32'd0, ex_pc}, {32'd0, e_pc});
    chk("ex_fields", {49'd0, ex_rs, ex_rt, ex_rd}, {49'd0, e_fields});
    chk("illegal_op", {63'd0, illegal_op}, {63'd0, m_illegal});
  endtask

  initial begin
    logic [31:0] ins;
    logic [5:0]  op;
    int          sel;

    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_mem_read = 1'b0; m_rt = 5'd0; m_kill = 1'b0; m_illegal = 1'b0;
    rst = 1'b1; instr_in = 32'd0; pc_in = 32'd0; flush_in = 1'b0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;

    // Reset for two cycles with a jump presented: no jump, no stall, ID/EX cleared.
    step(1, 32'h0800000C, 32'h10, 0, 0, 5'd0, 32'd0);
    step(1, 32'h0800000C, 32'h11, 0, 0, 5'd0, 32'd0);
    // Read $8 after reset.
    step(0, 32'h01000020, 32'h20, 0, 0, 5'd0, 32'd0);

    // R-type with operands written through WB.
    step(0, 32'h00000000, 32'h21, 0, 1, 5'd16, 32'd5);
    step(0, 32'h00000000, 32'h22, 0, 1, 5'd17, 32'd7);
    step(0, 32'h02114020, 32'h23, 0, 0, 5'd0, 32'd0);

    // Load-use pair: stall once, then the add is re-decoded.
    step(0, 32'h8E280004, 32'h24, 0, 0, 5'd0, 32'd0);
    step(0, 32'h01104820, 32'h25, 0, 0, 5'd0, 32'd0);
    step(0, 32'h01104820, 32'h25, 0, 0, 5'd0, 32'd0);

    // Jump, then a second jump in the squash slot must not redirect.
    step(0, 32'h0800000C, 32'h26, 0, 0, 5'd0, 32'd0);
    step(0, 32'h08000123, 32'h27, 0, 0, 5'd0, 32'd0);
    step(0, 32'h02114020, 32'h0C, 0, 0, 5'd0, 32'd0);

    // Bypass of $17, and writes to $0 reading back as zero.
    step(0, 32'h02204020, 32'h30, 0, 1, 5'd17, 32'hDEADBEEF);
    step(0, 32'h00004020, 32'h31, 0, 1, 5'd0, 32'h12345678);
    step(0, 32'h00004020, 32'h32, 0, 0, 5'd0, 32'd0);

    // Flush during a load-use pair: two bubbles, no stall, then normal decode.
    step(0, 32'h8E280004, 32'h40, 0, 0, 5'd0, 32'd0);
    step(0, 32'h01104820, 32'h41, 1, 0, 5'd0, 32'd0);
    step(0, 32'h01104820, 32'h42, 0, 0, 5'd0, 32'd0);
    step(0, 32'h01104820, 32'h43, 0, 0, 5'd0, 32'd0);

    // Unknown opcode sets the sticky flag; reset in SQUASH leaves no pending squash.
    step(0, 32'hFC000000, 32'h50, 0, 0, 5'd0, 32'd0);
    step(0, 32'h00000000, 32'h51, 0, 0, 5'd0, 32'd0);
    step(0, 32'h0800000C, 32'h52, 0, 0, 5'd0, 32'd0);
    step(1, 32'h02114020, 32'h53, 0, 0, 5'd0, 32'd0);
    step(0, 32'h8E280004, 32'h54, 0, 0, 5'd0, 32'd0);
    step(0, 32'h01104820, 32'h55, 0, 0, 5'd0, 32'd0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 29);
      if (sel < 9)       op = 6'h00;
      else if (sel < 16) op = 6'h23;
      else if (sel < 21) op = 6'h2B;
      else if (sel < 25) op = 6'h04;
      else if (sel < 29) op = 6'h02;
      else               op = 6'h08;
      ins = $urandom;
      ins[31:26] = op;
      if (op != 6'h02) begin
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        ins[15:11] = 5'($urandom_range(0, 7));
      end
      step(($urandom_range(0, 59) == 0), ins, $urandom, ($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
